// File: rtl/uart_frame_if.sv
// Handshake bundle between word producers, the frame scheduler and the uart_tx byte port.
// Valid/ready rule: a word or byte transfers on a clock edge where its valid and ready are both high.
interface uart_frame_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ*16-1:0] req_data;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [7:0]            tx_byte;
    logic                  tx_byte_valid;
    logic                  tx_byte_ready;

    modport master (
        output req_data, req_valid, tx_byte_ready,
        input  req_ready, tx_byte, tx_byte_valid
    );

    modport slave (
        input  req_data, req_valid, tx_byte_ready,
        output req_ready, tx_byte, tx_byte_valid
    );
endinterface

// File: rtl/uart_frame_scheduler.sv
// Round-robin arbiter that wraps one 16-bit word per grant into a 5-byte frame
// (header, source id, data hi, data lo, xor checksum) for the uart_tx byte port.
module uart_frame_scheduler #(
    parameter int          NUM_REQ     = 4,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int          TIMEOUT_CYC = 4096,
    parameter int          IDW         = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_frame_if.slave     bus,
    output logic            busy,
    output logic [IDW-1:0]  grant_id,
    output logic            timeout_err,
    output logic [15:0]     frame_cnt,
    output logic [2:0]      state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        ID   = 3'd2,
        HI   = 3'd3,
        LO   = 3'd4,
        CHK  = 3'd5
    } state_t;

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TLIM = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [15:0]     word;
    logic [TW-1:0]   tcnt;
    logic            any_valid;
    logic [IDW-1:0]  winner;
    logic [7:0]      id_byte;
    logic [7:0]      chk_byte;

    assign state_dbg = state;
    assign id_byte   = {{(8-IDW){1'b0}}, grant_id};
    assign chk_byte  = HEADER ^ id_byte ^ word[15:8] ^ word[7:0];

    // Scan downward so the smallest distance from rr_ptr is the last (winning) write.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = IDW'(idx);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == IDLE && any_valid) bus.req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            word              <= '0;
            tcnt              <= '0;
            bus.tx_byte       <= '0;
            bus.tx_byte_valid <= 1'b0;
            busy              <= 1'b0;
            grant_id          <= '0;
            timeout_err       <= 1'b0;
            frame_cnt         <= '0;
        end else begin
            timeout_err <= 1'b0;
            if (state == IDLE) begin
                if (any_valid) begin
                    word              <= bus.req_data[16*int'(winner) +: 16];
                    grant_id          <= winner;
                    rr_ptr            <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state             <= HDR;
                    bus.tx_byte       <= HEADER;
                    bus.tx_byte_valid <= 1'b1;
                    busy              <= 1'b1;
                    tcnt              <= '0;
                end
            end else if (bus.tx_byte_ready) begin
                // tx_byte_valid is always high in byte states, so ready alone marks a transfer.
                tcnt <= '0;
                case (state)
                    HDR: begin
                        bus.tx_byte <= id_byte;
                        state       <= ID;
                    end
                    ID: begin
                        bus.tx_byte <= word[15:8];
                        state       <= HI;
                    end
                    HI: begin
                        bus.tx_byte <= word[7:0];
                        state       <= LO;
                    end
                    LO: begin
                        bus.tx_byte <= chk_byte;
                        state       <= CHK;
                    end
                    default: begin
                        bus.tx_byte_valid <= 1'b0;
                        busy              <= 1'b0;
                        frame_cnt         <= frame_cnt + 16'd1;
                        state             <= IDLE;
                    end
                endcase
            end else if (TIMEOUT_CYC != 0) begin
                if (tcnt == TLIM) begin
                    bus.tx_byte_valid <= 1'b0;
                    busy              <= 1'b0;
                    timeout_err       <= 1'b1;
                    tcnt              <= '0;
                    state             <= IDLE;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: a default instance and a short-timeout instance.
module tb_uart_frame_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_if #(.NUM_REQ(N)) mif ();
    uart_frame_if #(.NUM_REQ(N)) tif ();

    logic        busy, t_busy;
    logic [1:0]  gid, t_gid;
    logic        terr, t_terr;
    logic [15:0] fcnt, t_fcnt;
    logic [2:0]  st, t_st;

    uart_frame_scheduler #(.NUM_REQ(N), .HEADER(8'hA5), .TIMEOUT_CYC(4096)) dut (
        .clk(clk), .rst_n(rst_n), .bus(mif.slave), .busy(busy), .grant_id(gid),
        .timeout_err(terr), .frame_cnt(fcnt), .state_dbg(st)
    );

    uart_frame_scheduler #(.NUM_REQ(N), .HEADER(8'hA5), .TIMEOUT_CYC(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .bus(tif.slave), .busy(t_busy), .grant_id(t_gid),
        .timeout_err(t_terr), .frame_cnt(t_fcnt), .state_dbg(t_st)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] chk8(input logic [7:0] id, input logic [15:0] w);
        return 8'hA5 ^ id ^ w[15:8] ^ w[7:0];
    endfunction

    // Expects the main DUT idle with requester id winning; runs one full frame at ready=1.
    task automatic frame_main(input int id, input logic [15:0] w, input logic [N-1:0] valid_after);
        logic [7:0]   eb [5];
        logic [N-1:0] onehot;
        eb[0] = 8'hA5;
        eb[1] = 8'(id);
        eb[2] = w[15:8];
        eb[3] = w[7:0];
        eb[4] = chk8(8'(id), w);
        onehot = '0;
        onehot[id] = 1'b1;
        #1;
        check("grant_ready", mif.req_ready, onehot);
        step();
        mif.req_valid = valid_after;
        check("grant_id", gid, id);
        check("busy_hi", busy, 1);
        for (int b = 0; b < 5; b++) begin
            check("byte_valid", mif.tx_byte_valid, 1);
            check("byte_val", mif.tx_byte, eb[b]);
            if (b == 0) check("no_ready_busy", mif.req_ready, 0);
            step();
        end
    endtask

    initial begin
        mif.req_data = '0; mif.req_valid = '0; mif.tx_byte_ready = 1'b0;
        tif.req_data = '0; tif.req_valid = '0; tif.tx_byte_ready = 1'b0;

        // Reset: outputs at reset values, req_ready stays low even with requests pending.
        mif.req_valid = '1;
        repeat (3) step();
        check("rst_ready", mif.req_ready, 0);
        check("rst_tx_byte", mif.tx_byte, 0);
        check("rst_tx_valid", mif.tx_byte_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_gid", gid, 0);
        check("rst_terr", terr, 0);
        check("rst_fcnt", fcnt, 0);
        mif.req_valid = '0;
        rst_n = 1'b1;
        step();

        // Single frame: requester 2, word 1234 -> A5 02 12 34 81.
        mif.tx_byte_ready = 1'b1;
        mif.req_data[16*2 +: 16] = 16'h1234;
        mif.req_valid = 4'b0100;
        frame_main(2, 16'h1234, 4'b0000);
        check("t1_busy_lo", busy, 0);
        check("t1_valid_lo", mif.tx_byte_valid, 0);
        check("t1_fcnt", fcnt, 1);

        // Round robin with all requesters held valid; rr_ptr is 3 after granting 2.
        for (int i = 0; i < N; i++) mif.req_data[16*i +: 16] = 16'h1111 * 16'(i + 1);
        mif.req_valid = 4'b1111;
        frame_main(3, 16'h4444, 4'b1111);
        frame_main(0, 16'h1111, 4'b1111);
        frame_main(1, 16'h2222, 4'b1111);
        frame_main(2, 16'h3333, 4'b1111);
        frame_main(3, 16'h4444, 4'b0000);
        check("t2_fcnt", fcnt, 6);
        check("t2_idle", busy, 0);

        // Backpressure: ready high one cycle in 250; requester 1, word BEEF -> A5 01 BE EF F5.
        mif.tx_byte_ready = 1'b0;
        mif.req_data[16*1 +: 16] = 16'hBEEF;
        mif.req_valid = 4'b0010;
        #1;
        check("t3_grant", mif.req_ready, 4'b0010);
        step();
        mif.req_valid = '0;
        begin
            logic [7:0] eb [5];
            eb[0] = 8'hA5; eb[1] = 8'h01; eb[2] = 8'hBE; eb[3] = 8'hEF; eb[4] = 8'hF5;
            for (int b = 0; b < 5; b++) begin
                for (int c = 0; c < 249; c++) begin
                    check("t3_hold_valid", mif.tx_byte_valid, 1);
                    check("t3_hold_byte", mif.tx_byte, eb[b]);
                    check("t3_no_timeout", terr, 0);
                    step();
                end
                check("t3_byte", mif.tx_byte, eb[b]);
                mif.tx_byte_ready = 1'b1;
                step();
                mif.tx_byte_ready = 1'b0;
            end
        end
        check("t3_fcnt", fcnt, 7);
        check("t3_idle", busy, 0);

        // Timeout on the 16-cycle instance: ready stuck low once HI (5A) is presented.
        tif.tx_byte_ready = 1'b1;
        tif.req_data[16*0 +: 16] = 16'h5A5A;
        tif.req_valid = 4'b0001;
        #1;
        check("t4_grant", tif.req_ready, 4'b0001);
        step();
        tif.req_valid = '0;
        check("t4_hdr", tif.tx_byte, 8'hA5);
        step();
        check("t4_id", tif.tx_byte, 8'h00);
        step();
        tif.tx_byte_ready = 1'b0;
        check("t4_hi", tif.tx_byte, 8'h5A);
        for (int c = 1; c < 16; c++) begin
            step();
            check("t4_wait_valid", tif.tx_byte_valid, 1);
            check("t4_wait_terr", t_terr, 0);
        end
        step();
        check("t4_terr_pulse", t_terr, 1);
        check("t4_valid_drop", tif.tx_byte_valid, 0);
        check("t4_busy_lo", t_busy, 0);
        check("t4_fcnt", t_fcnt, 0);
        step();
        check("t4_terr_single", t_terr, 0);
        tif.tx_byte_ready = 1'b1;
        tif.req_data[16*1 +: 16] = 16'h0102;
        tif.req_valid = 4'b0010;
        #1;
        check("t4_next_grant", tif.req_ready, 4'b0010);
        step();
        tif.req_valid = '0;
        begin
            logic [7:0] eb [5];
            eb[0] = 8'hA5; eb[1] = 8'h01; eb[2] = 8'h01; eb[3] = 8'h02; eb[4] = 8'hA7;
            for (int b = 0; b < 5; b++) begin
                check("t4_next_byte", tif.tx_byte, eb[b]);
                step();
            end
        end
        check("t4_next_fcnt", t_fcnt, 1);

        // Reset during LO byte; rr_ptr is 2 before reset, so 0 after reset picks 1 over 3.
        mif.tx_byte_ready = 1'b1;
        mif.req_data[16*1 +: 16] = 16'hC0DE;
        mif.req_valid = 4'b0010;
        #1;
        check("t5_grant", mif.req_ready, 4'b0010);
        step();
        mif.req_valid = '0;
        step();
        step();
        step();
        check("t5_lo_byte", mif.tx_byte, 8'hDE);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_byte", mif.tx_byte, 0);
        check("t5_rst_valid", mif.tx_byte_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_gid", gid, 0);
        check("t5_rst_terr", terr, 0);
        check("t5_rst_fcnt", fcnt, 0);
        #2 rst_n = 1'b1;
        mif.req_data[16*3 +: 16] = 16'h7777;
        mif.req_data[16*1 +: 16] = 16'h00FF;
        mif.req_valid = 4'b1010;
        frame_main(1, 16'h00FF, 4'b0000);
        check("t5_fcnt", fcnt, 1);

        // Wrap: preset frame_cnt to FFFF, then one frame brings it to 0.
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        step();
        check("t6_preset", fcnt, 16'hFFFF);
        mif.req_data[16*2 +: 16] = 16'h0000;
        mif.req_valid = 4'b0100;
        frame_main(2, 16'h0000, 4'b0000);
        check("t6_wrap", fcnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
